// File: rtl/if_fetch_unit.sv
// if_fetch_unit: MIPS IF stage; owns the PC, issues single-outstanding imem requests, drains wrong-path responses.
// Optional FETCH_PERF_EN adds fetch_cnt/discard_cnt counters.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        exc_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_o,
  output logic [31:0] pcp4_o,
`ifdef FETCH_PERF_EN
  output logic [31:0] fetch_cnt,
  output logic [31:0] discard_cnt,
`endif
  output logic        out_valid
);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d, pcp4_q, pcp4_d, drain_addr_q, drain_addr_d;
  logic        out_valid_q, out_valid_d;
  logic        redirect;
  logic [31:0] target;
  assign redirect = exc_i | branch_taken_i | jump_i;
  assign target   = exc_i ? EXC_VECTOR : branch_taken_i ? branch_target_i : jump_target_i;
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    pcp4_d       = pcp4_q;
    drain_addr_d = drain_addr_q;
    out_valid_d  = out_valid_q;
    imem_req     = 1'b0;
    imem_addr    = pc_q;
    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
        pc_d    = redirect ? target : pc_q;
      end
      FETCH: begin
        imem_req = !out_valid_q || !stall;
        if (redirect) begin
          // flush overrides stall; an unanswered request must be drained first
          pc_d        = target;
          out_valid_d = 1'b0;
          if (imem_req && !imem_ack) begin
            drain_addr_d = pc_q;
            state_d      = DRAIN;
          end
        end else if (imem_req && imem_ack) begin
          instr_d     = imem_rdata;
          pcp4_d      = pc_q + 32'd4;
          pc_d        = pc_q + 32'd4;
          out_valid_d = 1'b1;
        end else if (out_valid_q && !stall) begin
          out_valid_d = 1'b0;
        end
      end
      DRAIN: begin
        imem_req    = 1'b1;
        imem_addr   = drain_addr_q;
        out_valid_d = 1'b0;
        pc_d        = redirect ? target : pc_q;
        state_d     = imem_ack ? FETCH : DRAIN;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      instr_q      <= '0;
      pcp4_q       <= '0;
      drain_addr_q <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      pcp4_q       <= pcp4_d;
      drain_addr_q <= drain_addr_d;
      out_valid_q  <= out_valid_d;
    end
  end
  assign instr_o   = instr_q;
  assign pcp4_o    = pcp4_q;
  assign out_valid = out_valid_q;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d, discard_cnt_q, discard_cnt_d;
  logic        deliver, discard;
  assign deliver = state_q == FETCH && !redirect && imem_req && imem_ack;
  assign discard = imem_ack && ((state_q == FETCH && redirect && imem_req) || state_q == DRAIN);
  always_comb begin
    fetch_cnt_d   = deliver ? fetch_cnt_q + 32'd1 : fetch_cnt_q;
    discard_cnt_d = discard ? discard_cnt_q + 32'd1 : discard_cnt_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_cnt_q   <= '0;
      discard_cnt_q <= '0;
    end else begin
      fetch_cnt_q   <= fetch_cnt_d;
      discard_cnt_q <= discard_cnt_d;
    end
  end
  assign fetch_cnt   = fetch_cnt_q;
  assign discard_cnt = discard_cnt_q;
`endif
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: table-driven directed bench for if_fetch_unit plus an async-reset sequence.
module tb_if_fetch_unit;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall = 1'b0, exc_i = 1'b0, branch_taken_i = 1'b0, jump_i = 1'b0, imem_ack = 1'b0;
  logic [31:0] branch_target_i = '0, jump_target_i = '0, imem_rdata = '0;
  logic        imem_req, out_valid;
  logic [31:0] imem_addr, instr_o, pcp4_o;
  int checks = 0, failures = 0;

  if_fetch_unit dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .exc_i(exc_i),
    .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
    .jump_i(jump_i), .jump_target_i(jump_target_i),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_o(instr_o), .pcp4_o(pcp4_o), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall, exc, br;
    logic [31:0] bt;
    logic        jmp;
    logic [31:0] jt;
    logic        ack;
    logic [31:0] rd;
    logic        req;
    logic [31:0] addr;
    logic        ov;
    logic [31:0] instr, pcp4;
  } vec_t;

  function automatic vec_t mk(logic s, logic e, logic b, logic [31:0] bt, logic j, logic [31:0] jt,
                              logic a, logic [31:0] rd, logic req, logic [31:0] addr,
                              logic ov, logic [31:0] instr, logic [31:0] pcp4);
    vec_t v;
    v.stall = s; v.exc = e; v.br = b; v.bt = bt; v.jmp = j; v.jt = jt; v.ack = a; v.rd = rd;
    v.req = req; v.addr = addr; v.ov = ov; v.instr = instr; v.pcp4 = pcp4;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=%h required=%h", name, idx, act, exp);
    end
  endtask

  localparam logic [31:0] I0 = 32'hA000_0000, I1 = 32'hA000_0001, I2 = 32'hA000_0002, I3 = 32'hA000_0003;
  localparam logic [31:0] I4 = 32'hA000_0004, I5 = 32'hA000_0005, I6 = 32'hA000_0006, I7 = 32'hA000_0007;
  localparam logic [31:0] I8 = 32'hA000_0008, BAD = 32'hDEAD_BEEF;

  vec_t tbl[23];

  initial begin
    //                stall exc br  bt            jmp jt            ack rdata  req addr           ov instr pcp4
    tbl[0]  = mk(0, 0, 0, 32'h0,         0, 32'h0,         1, BAD, 0, 32'h0040_0000, 0, 32'h0, 32'h0);
    tbl[1]  = mk(0, 0, 0, 32'h0,         0, 32'h0,         1, I0,  1, 32'h0040_0000, 1, I0, 32'h0040_0004);
    tbl[2]  = mk(0, 0, 0, 32'h0,         0, 32'h0,         1, I1,  1, 32'h0040_0004, 1, I1, 32'h0040_0008);
    tbl[3]  = mk(0, 0, 0, 32'h0,         0, 32'h0,         1, I2,  1, 32'h0040_0008, 1, I2, 32'h0040_000C);
    tbl[4]  = mk(1, 0, 0, 32'h0,         0, 32'h0,         1, BAD, 0, 32'h0040_000C, 1, I2, 32'h0040_000C);
    tbl[5]  = mk(1, 0, 0, 32'h0,         0, 32'h0,         1, BAD, 0, 32'h0040_000C, 1, I2, 32'h0040_000C);
    tbl[6]  = mk(1, 0, 0, 32'h0,         0, 32'h0,         1, BAD, 0, 32'h0040_000C, 1, I2, 32'h0040_000C);
    tbl[7]  = mk(0, 0, 0, 32'h0,         0, 32'h0,         1, I3,  1, 32'h0040_000C, 1, I3, 32'h0040_0010);
    tbl[8]  = mk(0, 0, 1, 32'h0040_0100, 0, 32'h0,         0, BAD, 1, 32'h0040_0010, 0, I3, 32'h0040_0010);
    tbl[9]  = mk(0, 0, 0, 32'h0,         0, 32'h0,         0, BAD, 1, 32'h0040_0010, 0, I3, 32'h0040_0010);
    tbl[10] = mk(0, 0, 0, 32'h0,         0, 32'h0,         1, BAD, 1, 32'h0040_0010, 0, I3, 32'h0040_0010);
    tbl[11] = mk(0, 0, 0, 32'h0,         0, 32'h0,         1, I4,  1, 32'h0040_0100, 1, I4, 32'h0040_0104);
    tbl[12] = mk(1, 1, 1, 32'h0000_0123, 1, 32'h0000_0456, 1, BAD, 0, 32'h0040_0104, 0, I4, 32'h0040_0104);
    tbl[13] = mk(0, 0, 0, 32'h0,         0, 32'h0,         1, I5,  1, 32'h8000_0180, 1, I5, 32'h8000_0184);
    tbl[14] = mk(0, 0, 0, 32'h0,         1, 32'hFFFF_FFFC, 1, BAD, 1, 32'h8000_0184, 0, I5, 32'h8000_0184);
    tbl[15] = mk(0, 0, 0, 32'h0,         0, 32'h0,         1, I6,  1, 32'hFFFF_FFFC, 1, I6, 32'h0000_0000);
    tbl[16] = mk(0, 0, 0, 32'h0,         0, 32'h0,         0, BAD, 1, 32'h0000_0000, 0, I6, 32'h0000_0000);
    tbl[17] = mk(0, 0, 1, 32'h0000_0200, 1, 32'h0000_0300, 1, BAD, 1, 32'h0000_0000, 0, I6, 32'h0000_0000);
    tbl[18] = mk(0, 0, 0, 32'h0,         0, 32'h0,         1, I7,  1, 32'h0000_0200, 1, I7, 32'h0000_0204);
    tbl[19] = mk(0, 0, 0, 32'h0,         1, 32'h0000_0300, 0, BAD, 1, 32'h0000_0204, 0, I7, 32'h0000_0204);
    tbl[20] = mk(0, 1, 0, 32'h0,         0, 32'h0,         0, BAD, 1, 32'h0000_0204, 0, I7, 32'h0000_0204);
    tbl[21] = mk(0, 0, 0, 32'h0,         0, 32'h0,         1, BAD, 1, 32'h0000_0204, 0, I7, 32'h0000_0204);
    tbl[22] = mk(0, 0, 0, 32'h0,         0, 32'h0,         1, I8,  1, 32'h8000_0180, 1, I8, 32'h8000_0184);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_req", -1, {31'b0, imem_req}, 32'd0);
    chk("reset_valid", -1, {31'b0, out_valid}, 32'd0);
    chk("reset_instr", -1, instr_o, 32'h0);
    chk("reset_pcp4", -1, pcp4_o, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 23; i++) begin
      if (i > 0) @(negedge clk);
      stall = tbl[i].stall; exc_i = tbl[i].exc; branch_taken_i = tbl[i].br; branch_target_i = tbl[i].bt;
      jump_i = tbl[i].jmp; jump_target_i = tbl[i].jt; imem_ack = tbl[i].ack; imem_rdata = tbl[i].rd;
      #1;
      chk("imem_req", i, {31'b0, imem_req}, {31'b0, tbl[i].req});
      chk("imem_addr", i, imem_addr, tbl[i].addr);
      @(posedge clk);
      #1;
      chk("out_valid", i, {31'b0, out_valid}, {31'b0, tbl[i].ov});
      chk("instr_o", i, instr_o, tbl[i].instr);
      chk("pcp4_o", i, pcp4_o, tbl[i].pcp4);
    end

    // reset asserted mid-request must clear outputs before any clock edge
    @(negedge clk);
    stall = 1'b0; exc_i = 1'b0; branch_taken_i = 1'b0; jump_i = 1'b0; imem_ack = 1'b0;
    #1;
    chk("pre_reset_req", 23, {31'b0, imem_req}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("async_reset_req", 23, {31'b0, imem_req}, 32'd0);
    chk("async_reset_valid", 23, {31'b0, out_valid}, 32'd0);
    chk("async_reset_pcp4", 23, pcp4_o, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch front end of the five-stage MIPS pipeline.
- Owns the program counter and issues single-outstanding requests to instruction memory.
- Delivers the fetched instruction and PC+4 to the IF/ID pipeline register.
- Honours hazard stalls and redirects (exception, EX branch, ID jump), and drains any in-flight response after a redirect so no wrong-path instruction is delivered.

Parameters:
RESET_PC, 32'h0040_0000, PC loaded on reset
EXC_VECTOR, 32'h8000_0180, PC loaded on exception redirect

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous active-low reset
stall  input  1  hazard unit; IF/ID must hold its contents
exc_i  input  1  exception redirect request
branch_taken_i  input  1  EX-stage taken branch
branch_target_i  input  32  branch target
jump_i  input  1  ID-stage jump
jump_target_i  input  32  jump target
imem_req  output  1  instruction memory request
imem_addr  output  32  request address; stable while imem_req=1 and imem_ack=0
imem_ack  input  1  response valid this cycle; may arrive in the same cycle as imem_req
imem_rdata  input  32  instruction word, valid when imem_ack=1
instr_o  output  32  fetched instruction to IF/ID
pcp4_o  output  32  PC+4 of instr_o
out_valid  output  1  instr_o/pcp4_o hold a valid instruction

Behaviour:
- Reset (reset_n=0, async):
  - pc=RESET_PC, state=IDLE, out_valid=0, instr_o=0, pcp4_o=0, imem_req=0, drain_addr=0.
- States:
  - IDLE: one cycle after reset release, then FETCH.
  - FETCH: normal fetching.
  - DRAIN: waiting on a wrong-path response.
- Redirect and its target: redirect = exc_i|branch_taken_i|jump_i.
  - Target priority: exc_i (EXC_VECTOR) > branch_taken_i > jump_i.
- FETCH request:
  - imem_req = !out_valid || !stall (output slot free or being consumed); imem_addr = pc.
- FETCH, imem_req & imem_ack & no redirect:
  - Next edge: instr_o=imem_rdata, pcp4_o=pc+4, out_valid=1, pc=pc+4.
  - Zero-wait memory gives 1 instruction/cycle.
- FETCH, no ack:
  - out_valid cleared if out_valid & !stall (consumed); otherwise held.
- Stall:
  - When out_valid=1 and stall=1, instr_o/pcp4_o/out_valid hold and no new request issues.
- Redirect in FETCH:
  - pc=target, out_valid=0 (flush, overrides stall).
  - If imem_req=1 & imem_ack=1: response discarded, stay FETCH.
  - If imem_req=1 & imem_ack=0: drain_addr=pc (old), go DRAIN.
  - If imem_req=0: stay FETCH.
- DRAIN:
  - imem_req=1, imem_addr=drain_addr, out_valid=0.
  - On imem_ack, data discarded, go FETCH (new request at pc next cycle).
  - Redirect in DRAIN only updates pc; stays DRAIN until ack.
- Arithmetic:
  - pc+4 is 32-bit modulo, so 32'hFFFF_FFFC wraps to 0.
  - Targets are used as given; low bits are not masked.
- Simultaneous stall & redirect: redirect wins.
- Reset mid-request: pending request abandoned; memory must tolerate a dropped request.

Optional Feature:
FETCH_PERF_EN
- Defined: adds outputs fetch_cnt[31:0] and discard_cnt[31:0], both reset to 0 and wrapping.
  - fetch_cnt increments on each delivered instruction (out_valid rising or reloaded).
  - discard_cnt increments on each response dropped due to redirect or DRAIN.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset release, imem_ack tied high -> imem_addr 0x00400000, 0x00400004, 0x00400008 on consecutive cycles; pcp4_o 0x00400004 with out_valid=1 one cycle after first ack.
- out_valid=1, stall held 3 cycles -> imem_req=0, instr_o/pcp4_o unchanged; stall drop -> next request addr = previous pcp4_o.
- Request to 0x00400010 pending with 2-cycle ack delay, branch_taken_i=1 target 0x00400100 -> DRAIN, imem_addr stays 0x00400010 until ack, data dropped, out_valid=0, next request 0x00400100.
- exc_i, branch_taken_i, jump_i all 1 in the same cycle with stall=1 -> pc=0x80000180, out_valid=0 next cycle.
- pc=0xFFFFFFFC with ack -> pcp4_o=0x00000000, next imem_addr=0x00000000.
- reset_n asserted while imem_req=1 -> imem_req=0 and out_valid=0 immediately, without waiting for a clock edge.
